// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch unit and the load/store unit.
// Data accesses have priority. A starvation guard forces a fetch grant after STARVE_LIMIT back-to-back data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned AW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    DPRI,
    FPRI
  } arbState_e;

  arbState_e       state;
  arbState_e       stateNext;
  logic [CW-1:0]   starveCnt;
  logic [CW-1:0]   starveCntNext;
  logic            ifGrant;
  logic            dGrant;
  logic            ifRvalidQ;
  logic            dRvalidQ;
  logic [31:0]     ifRdataQ;
  logic [31:0]     dRdataQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DPRI;
      starveCnt <= '0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveCntNext;
    end
  end

  always_comb begin
    ifGrant       = 1'b0;
    dGrant        = 1'b0;
    stateNext     = state;
    starveCntNext = starveCnt;

    if (!reset) begin
      unique case (state)
        DPRI: begin
          if (d_req)       dGrant  = 1'b1;
          else if (if_req) ifGrant = 1'b1;
        end
        FPRI: begin
          if (if_req)      ifGrant = 1'b1;
          else if (d_req)  dGrant  = 1'b1;
        end
        default: ;
      endcase
    end

    if (ifGrant || !if_req) starveCntNext = '0;
    else if (dGrant)        starveCntNext = starveCnt + CW'(1);

    // FPRI is entered on the same edge the counter reaches the limit.
    unique case (state)
      DPRI:    if (starveCntNext == CW'(STARVE_LIMIT)) stateNext = FPRI;
      FPRI:    if (ifGrant || !if_req)                 stateNext = DPRI;
      default: stateNext = DPRI;
    endcase
  end

  assign if_gnt    = ifGrant;
  assign d_gnt     = dGrant;
  assign mem_addr  = ifGrant ? if_addr : (dGrant ? d_addr : '0);
  assign mem_we    = dGrant & d_we;
  assign mem_wdata = dGrant ? d_wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ifRvalidQ <= 1'b0;
      dRvalidQ  <= 1'b0;
      ifRdataQ  <= '0;
      dRdataQ   <= '0;
    end else begin
      ifRvalidQ <= ifGrant;
      dRvalidQ  <= dGrant & ~d_we;
      if (ifGrant)          ifRdataQ <= mem_rdata;
      if (dGrant && !d_we)  dRdataQ  <= mem_rdata;
    end
  end

  // Responses are masked while reset is high so a read granted just before reset is dropped.
  assign if_rvalid = ifRvalidQ & ~reset;
  assign d_rvalid  = dRvalidQ & ~reset;
  assign if_rdata  = reset ? '0 : ifRdataQ;
  assign d_rdata   = reset ? '0 : dRdataQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a priority/starvation reference model.
module tb_mem_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] memArr [64];

  int checks = 0;
  int errors = 0;

  // reference model state
  int          run = 0;
  logic        expIfRvalid = 1'b0;
  logic        expDRvalid  = 1'b0;
  logic [31:0] expIfRdata  = '0;
  logic [31:0] expDRdata   = '0;
  logic        lastIfGnt   = 1'b0;
  logic        lastDGnt    = 1'b0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .AW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = memArr[mem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running after 2000000 time units");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare one cycle against the model at the falling edge, advance the model, then move to just after the next rising edge.
  task automatic tick();
    logic        fG, dG, eWe;
    logic [31:0] eAddr, eWd;
    @(negedge clk);
    fG = 1'b0; dG = 1'b0;
    if (!reset) begin
      fG = if_req && (!d_req || run >= int'(LIMIT));
      dG = d_req && !fG;
    end
    eAddr = fG ? if_addr : (dG ? d_addr : 32'h0);
    eWe   = dG && d_we;
    eWd   = dG ? d_wdata : 32'h0;
    check("if_gnt",    {31'b0, if_gnt},    {31'b0, fG});
    check("d_gnt",     {31'b0, d_gnt},     {31'b0, dG});
    check("mem_addr",  mem_addr,           eAddr);
    check("mem_we",    {31'b0, mem_we},    {31'b0, eWe});
    check("mem_wdata", mem_wdata,          eWd);
    check("if_rvalid", {31'b0, if_rvalid}, {31'b0, expIfRvalid && !reset});
    check("d_rvalid",  {31'b0, d_rvalid},  {31'b0, expDRvalid && !reset});
    check("if_rdata",  if_rdata,           reset ? 32'h0 : expIfRdata);
    check("d_rdata",   d_rdata,            reset ? 32'h0 : expDRdata);

    if (reset) begin
      run = 0;
      expIfRvalid = 1'b0; expDRvalid = 1'b0;
      expIfRdata  = '0;   expDRdata  = '0;
    end else begin
      expIfRvalid = fG;
      if (fG) expIfRdata = memArr[if_addr[7:2]];
      expDRvalid = dG && !d_we;
      if (dG && !d_we) expDRdata = memArr[d_addr[7:2]];
      if (dG && if_req)       run++;
      else if (fG || !if_req) run = 0;
    end
    if (mem_we) memArr[mem_addr[7:2]] = mem_wdata;
    lastIfGnt = fG;
    lastDGnt  = dG;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    int ifPct;
    int dPct;
    for (int i = 0; i < 64; i++) memArr[i] = $urandom;
    memArr[0] = 32'h2004000a;
    memArr[4] = 32'h11040003;
    memArr[5] = 32'h01284820;

    reset = 1'b1;
    idleInputs();
    @(posedge clk); #1;
    tick();
    check("rst if_gnt", {31'b0, if_gnt}, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    tick();
    reset = 1'b0;

    // fetch alone from address 0
    if_req = 1'b1; if_addr = 32'h0;
    #1 check("t1 if_gnt", {31'b0, if_gnt}, 32'h1);
    check("t1 mem_addr", mem_addr, 32'h0);
    tick();
    if_req = 1'b0;
    #1 check("t1 if_rvalid", {31'b0, if_rvalid}, 32'h1);
    check("t1 if_rdata", if_rdata, 32'h2004000a);
    tick();
    #1 check("t1 if_rvalid low", {31'b0, if_rvalid}, 32'h0);
    tick();

    // simultaneous fetch and load in DPRI: data first
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    #1 check("t2 d_gnt", {31'b0, d_gnt}, 32'h1);
    check("t2 if_gnt c0", {31'b0, if_gnt}, 32'h0);
    tick();
    d_req = 1'b0;
    #1 check("t2 d_rvalid", {31'b0, d_rvalid}, 32'h1);
    check("t2 d_rdata", d_rdata, 32'h01284820);
    check("t2 if_gnt c1", {31'b0, if_gnt}, 32'h1);
    tick();
    if_req = 1'b0;
    #1 check("t2 if_rvalid", {31'b0, if_rvalid}, 32'h1);
    check("t2 if_rdata", if_rdata, 32'h11040003);
    tick();

    // store, reload, load with junk wdata
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hFFFFFFFC; d_wdata = 32'h12345678;
    #1 check("t3 d_gnt", {31'b0, d_gnt}, 32'h1);
    check("t3 mem_we", {31'b0, mem_we}, 32'h1);
    tick();
    d_we = 1'b0; d_wdata = 32'h0;
    #1 check("t3 no store rvalid", {31'b0, d_rvalid}, 32'h0);
    tick();
    d_wdata = 32'habcdef90;
    #1 check("t3 load rdata", d_rdata, 32'h12345678);
    check("t3 load mem_we", {31'b0, mem_we}, 32'h0);
    tick();
    d_req = 1'b0;
    #1 check("t3 reload rdata", d_rdata, 32'h12345678);
    tick();
    idleInputs();
    tick();

    // both held continuously: 4 data grants then a forced fetch
    for (int c = 0; c < 12; c++) begin
      if_req = 1'b1; if_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
      #1 check("t4 if_gnt", {31'b0, if_gnt}, (c % 5 == 4) ? 32'h1 : 32'h0);
      check("t4 d_gnt", {31'b0, d_gnt}, (c % 5 == 4) ? 32'h0 : 32'h1);
      tick();
    end
    idleInputs();
    tick();

    // reset while in FPRI with a load response in flight
    for (int c = 0; c < 4; c++) begin
      if_req = 1'b1; if_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
      #1 check("t5 d_gnt", {31'b0, d_gnt}, 32'h1);
      tick();
    end
    reset = 1'b1;
    #1 check("t5 rst d_rvalid", {31'b0, d_rvalid}, 32'h0);
    check("t5 rst if_gnt", {31'b0, if_gnt}, 32'h0);
    check("t5 rst d_gnt", {31'b0, d_gnt}, 32'h0);
    check("t5 rst mem_addr", mem_addr, 32'h0);
    tick();
    reset = 1'b0;
    #1 check("t5 post d_rvalid", {31'b0, d_rvalid}, 32'h0);
    check("t5 post d_gnt DPRI", {31'b0, d_gnt}, 32'h1);
    check("t5 post if_gnt", {31'b0, if_gnt}, 32'h0);
    tick();
    idleInputs();

    // idle for 10 cycles
    for (int c = 0; c < 10; c++) begin
      #1 check("t6 idle gnt", {30'b0, if_gnt, d_gnt}, 32'h0);
      tick();
    end

    // randomized traffic; requests are held until granted
    ifPct = 50; dPct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        ifPct = ($urandom_range(0, 2) == 0) ? 20 : (($urandom_range(0, 1) == 0) ? 60 : 95);
        dPct  = ($urandom_range(0, 2) == 0) ? 20 : (($urandom_range(0, 1) == 0) ? 60 : 95);
      end
      reset = ($urandom_range(0, 199) == 0);
      if (!if_req || lastIfGnt) begin
        if_req  = ($urandom_range(0, 99) < ifPct);
        if_addr = $urandom;
      end
      if (!d_req || lastDGnt) begin
        d_req   = ($urandom_range(0, 99) < dPct);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
